hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It is the producer of the stall and flush controls that the fetch/decode and decode/execute pipeline registers consume, including the `clear` input of the decode/execute register. It also computes the operand forwarding selects for the execute and decode stages. It tracks the multi-cycle HI/LO (mult/div) unit with a busy counter so that HI/LO consumers stall until the result is ready.

## Interface
- MULT_CYCLES, 4, cycles HI/LO is busy after a mult/multu enters execute (1..63)
- DIV_CYCLES, 32, cycles HI/LO is busy after a div/divu enters execute (1..63)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- Rs_decode, Rt_decode  in  5 each  source registers in decode
- Rs_execute, Rt_execute  in  5 each  source registers in execute
- write_register_execute / _memory / _writeback  in  5 each  destination register per stage
- register_write_execute / _memory / _writeback  in  1 each  stage will write the register file
- memory_to_register_execute, memory_to_register_memory  in  1 each  stage holds a load
- branch_decode  in  1  branch resolving in decode
- hi_lo_read_decode  in  1  mfhi/mflo in decode
- hi_lo_start_decode  in  1  mult/div in decode
- hi_lo_start_execute  in  1  mult/div in execute (this cycle)
- hi_lo_divide_execute  in  1  qualifies hi_lo_start_execute: 1 = div, 0 = mult
- stall_fetch, stall_decode  out  1 each  hold PC and fetch/decode register
- flush_execute  out  1  drives decode/execute register `clear`
- forward_A_execute, forward_B_execute  out  2 each  ALU operand select
- forward_A_decode, forward_B_decode  out  1 each  branch comparator forward from memory stage
- hi_lo_busy  out  1  HI/LO result not yet valid

## Operation
**Execute forwarding (A uses Rs_execute, B uses Rt_execute)**
- 2'b10 when register_write_memory and write_register_memory ≠ 0 and matches the source register.
- Else 2'b01 when the same conditions hold for the writeback stage.
- Else 2'b00.
- Memory has priority over writeback.
- Register 0 is never forwarded.

**Decode forwarding**
- forward_X_decode = 1 when Rx_decode ≠ 0, register_write_memory, and write_register_memory == Rx_decode.

**Load-use stall (lw_stall)**
- Asserted when memory_to_register_execute, register_write_execute, write_register_execute ≠ 0, and write_register_execute equals Rs_decode or Rt_decode.

**Branch stall (branch_stall)**
- Requires branch_decode, and one of the following:
  - register_write_execute with write_register_execute ≠ 0 matching Rs_decode or Rt_decode; or
  - memory_to_register_memory with write_register_memory ≠ 0 matching Rs_decode or Rt_decode.

**HI/LO tracking**
- Registered 6-bit busy_count.
- On a clk edge with hi_lo_start_execute and busy_count == 0, load DIV_CYCLES if hi_lo_divide_execute, else MULT_CYCLES.
- Otherwise, if busy_count ≠ 0, decrement by 1.
- States: IDLE (count = 0) → BUSY on start; BUSY → IDLE when count reaches 0.
- hi_lo_busy = (busy_count ≠ 0) OR hi_lo_start_execute. This is combinational, so a back-to-back HI/LO consumer sees busy in the start cycle.
- hi_lo_stall = hi_lo_busy AND (hi_lo_read_decode OR hi_lo_start_decode).
- A start arriving while busy_count ≠ 0 is a protocol violation. It is ignored: the count is neither reloaded nor disturbed.

**Outputs**
- stall_fetch = stall_decode = flush_execute = lw_stall OR branch_stall OR hi_lo_stall.

## Timing
- All stall, flush and forward outputs are combinational from inputs and busy_count, valid in the same cycle.
- Only busy_count is state. Reset clears it to 0 asynchronously, including mid-operation.
- Reset values with all inputs 0: every stall/flush output 0, forward selects 0, hi_lo_busy 0.
- HI/LO latency:
  - Start sampled at edge E0; hi_lo_busy is high in the E0 cycle and for N cycles after.
  - busy_count goes N, N-1, …, 1, then 0.
  - A waiting mfhi leaves decode on the first edge where count == 0 and no start is in execute.
- Simultaneous causes OR together. A stall asserted in the cycle busy_count reaches 0 depends only on the other causes.

## Test plan
- Forwarding priority: Rs_execute = 5, memory and writeback both write r5 → forward_A_execute = 2'b10. Writeback only → 2'b01. Rs_execute = 0 with r0 writes → 2'b00.
- Load-use: lw to r8 in execute, Rt_decode = 8 → stall_fetch = stall_decode = flush_execute = 1 for one cycle. Next cycle (load in memory, bubble in execute) → all 0.
- Branch: branch_decode with Rs_decode = 3 and execute ALU writing r3 → stall for 1 cycle. Load to r3 in memory → stall. ALU result for r3 in memory → no stall, forward_A_decode = 1.
- Mult then mfhi: hi_lo_start_execute with divide = 0 and hi_lo_read_decode = 1 → stalls in the start cycle plus 4 more cycles (5 total), then 0. busy_count sequence 4, 3, 2, 1, 0.
- Div with reset mid-op: start div, assert reset when busy_count = 20 → busy_count = 0, hi_lo_busy = 0, and stalls drop immediately.
- Start while busy: div at count 32, mult start at count 10 → count continues 9, 8, … (no reload to 4).

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: pipeline-stage register/control fields in, stall/flush/forward controls out.
interface hazard_unit_if;
    logic [4:0] Rs_decode;
    logic [4:0] Rt_decode;
    logic [4:0] Rs_execute;
    logic [4:0] Rt_execute;
    logic [4:0] write_register_execute;
    logic [4:0] write_register_memory;
    logic [4:0] write_register_writeback;
    logic       register_write_execute;
    logic       register_write_memory;
    logic       register_write_writeback;
    logic       memory_to_register_execute;
    logic       memory_to_register_memory;
    logic       branch_decode;
    logic       hi_lo_read_decode;
    logic       hi_lo_start_decode;
    logic       hi_lo_start_execute;
    logic       hi_lo_divide_execute;
    logic       stall_fetch;
    logic       stall_decode;
    logic       flush_execute;
    logic [1:0] forward_A_execute;
    logic [1:0] forward_B_execute;
    logic       forward_A_decode;
    logic       forward_B_decode;
    logic       hi_lo_busy;

    // pipeline side
    modport master (
        output Rs_decode, Rt_decode, Rs_execute, Rt_execute,
               write_register_execute, write_register_memory, write_register_writeback,
               register_write_execute, register_write_memory, register_write_writeback,
               memory_to_register_execute, memory_to_register_memory, branch_decode,
               hi_lo_read_decode, hi_lo_start_decode, hi_lo_start_execute, hi_lo_divide_execute,
        input  stall_fetch, stall_decode, flush_execute, forward_A_execute, forward_B_execute,
               forward_A_decode, forward_B_decode, hi_lo_busy
    );

    // hazard unit side
    modport slave (
        input  Rs_decode, Rt_decode, Rs_execute, Rt_execute,
               write_register_execute, write_register_memory, write_register_writeback,
               register_write_execute, register_write_memory, register_write_writeback,
               memory_to_register_execute, memory_to_register_memory, branch_decode,
               hi_lo_read_decode, hi_lo_start_decode, hi_lo_start_execute, hi_lo_divide_execute,
        output stall_fetch, stall_decode, flush_execute, forward_A_execute, forward_B_execute,
               forward_A_decode, forward_B_decode, hi_lo_busy
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage MIPS hazard controller: forwarding selects, load-use/branch stalls, HI/LO busy tracking.
//   state | meaning
//   IDLE  | busy_count == 0, HI/LO result valid
//   BUSY  | busy_count != 0, mult/div in flight
module hazard_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

    logic [5:0] busy_count;
    logic [0:0] hi_lo_state;
    logic       lw_stall;
    logic       branch_stall;
    logic       hi_lo_stall;
    logic       any_stall;
    logic       ex_hits_decode;
    logic       mem_hits_decode;

    assign hi_lo_state = (busy_count != 6'd0) ? ST_BUSY : ST_IDLE;

    // A start while BUSY is ignored; the running count is left untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_count <= 6'd0;
        end else if (hi_lo_state == ST_IDLE) begin
            if (hz.hi_lo_start_execute)
                busy_count <= hz.hi_lo_divide_execute ? DIV_LOAD : MULT_LOAD;
        end else begin
            busy_count <= busy_count - 6'd1;
        end
    end

    function automatic logic [1:0] fwd_execute(input logic [4:0] src);
        if (hz.register_write_memory && hz.write_register_memory != 5'd0 &&
            hz.write_register_memory == src)
            return 2'b10;
        else if (hz.register_write_writeback && hz.write_register_writeback != 5'd0 &&
                 hz.write_register_writeback == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign hz.forward_A_execute = fwd_execute(hz.Rs_execute);
    assign hz.forward_B_execute = fwd_execute(hz.Rt_execute);

    assign hz.forward_A_decode = (hz.Rs_decode != 5'd0) && hz.register_write_memory &&
                                 (hz.write_register_memory == hz.Rs_decode);
    assign hz.forward_B_decode = (hz.Rt_decode != 5'd0) && hz.register_write_memory &&
                                 (hz.write_register_memory == hz.Rt_decode);

    assign ex_hits_decode  = (hz.write_register_execute != 5'd0) &&
                             ((hz.write_register_execute == hz.Rs_decode) ||
                              (hz.write_register_execute == hz.Rt_decode));
    assign mem_hits_decode = (hz.write_register_memory != 5'd0) &&
                             ((hz.write_register_memory == hz.Rs_decode) ||
                              (hz.write_register_memory == hz.Rt_decode));

    assign lw_stall     = hz.memory_to_register_execute && hz.register_write_execute && ex_hits_decode;
    assign branch_stall = hz.branch_decode &&
                          ((hz.register_write_execute && ex_hits_decode) ||
                           (hz.memory_to_register_memory && mem_hits_decode));

    // Start term makes a back-to-back HI/LO consumer stall in the start cycle itself.
    assign hz.hi_lo_busy = (hi_lo_state == ST_BUSY) || hz.hi_lo_start_execute;
    assign hi_lo_stall   = hz.hi_lo_busy && (hz.hi_lo_read_decode || hz.hi_lo_start_decode);

    assign any_stall        = lw_stall || branch_stall || hi_lo_stall;
    assign hz.stall_fetch   = any_stall;
    assign hz.stall_decode  = any_stall;
    assign hz.flush_execute = any_stall;
endmodule
